// File: rtl/fmmu_seq_ctrl_if.sv
// ============================================================================
// Module   : fmmu_seq_ctrl_if
// Brief    : Process-RAM byte bus between the FMMU sequencer and the RAM.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface fmmu_seq_ctrl_if;
    logic [15:0] bus_addr;
    logic        bus_rd;
    logic        bus_wr;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;

    modport master (
        output bus_addr,
        output bus_rd,
        output bus_wr,
        output bus_wdata,
        input  bus_rdata
    );

    modport slave (
        input  bus_addr,
        input  bus_rd,
        input  bus_wr,
        input  bus_wdata,
        output bus_rdata
    );
endinterface

`default_nettype wire

// File: rtl/fmmu_seq_ctrl.sv
// ============================================================================
// Module   : fmmu_seq_ctrl
// Brief    : FMMU byte sequencer mapping logical datagram bytes to process RAM.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fmmu_seq_ctrl #(
    parameter logic [7:0] LOG_CMD_LRD = 8'd10,
    parameter logic [7:0] LOG_CMD_LWR = 8'd11,
    parameter logic [7:0] LOG_CMD_LRW = 8'd12
) (
    input  wire logic        rxc,
    input  wire logic        RSTN,
    input  wire logic        sub_start,
    input  wire logic [7:0]  sub_command,
    input  wire logic [31:0] sub_address,
    input  wire logic [15:0] sub_len,
    input  wire logic        rx_valid,
    input  wire logic [7:0]  rx_data,
    input  wire logic        frame_end,
    input  wire logic        cfg_enable,
    input  wire logic [31:0] cfg_log_start,
    input  wire logic [15:0] cfg_log_len,
    input  wire logic [15:0] cfg_phys_start,
    input  wire logic [1:0]  cfg_type,
    fmmu_seq_ctrl_if.master  bus,
    output logic             tx_valid,
    output logic [7:0]       tx_data,
    output logic             wkc_valid,
    output logic [1:0]       wkc_inc,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [7:0]  r_cmd;
    logic [31:0] r_addr;
    logic [15:0] r_len;
    logic [15:0] r_cnt;
    logic        r_rd_hit;
    logic        r_wr_hit;
    logic        r_rd_q;
    logic [7:0]  r_rx_q;

    logic        w_byte;
    logic        w_last;
    logic        w_is_log;
    logic [31:0] w_laddr;
    logic [32:0] w_off33;
    logic        w_hit;
    logic        w_rd;
    logic        w_wr;
    logic        w_rd_hit_nxt;
    logic        w_wr_hit_nxt;
    logic [1:0]  w_wkc;

    // A byte arriving together with a new header belongs to no datagram.
    assign w_byte   = (r_state == DATA) && rx_valid && !sub_start;
    assign w_last   = (r_cnt == r_len - 16'd1);
    assign w_is_log = (sub_command == LOG_CMD_LRD) || (sub_command == LOG_CMD_LWR) ||
                      (sub_command == LOG_CMD_LRW);

    // Bit 32 of the offset flags a byte below the window start.
    assign w_laddr = r_addr + {16'd0, r_cnt};
    assign w_off33 = {1'b0, w_laddr} - {1'b0, cfg_log_start};
    assign w_hit   = cfg_enable && (cfg_log_len != 16'd0) && !w_off33[32] &&
                     (w_off33[31:0] < {16'd0, cfg_log_len});

    assign w_rd = w_byte && w_hit && cfg_type[0] &&
                  ((r_cmd == LOG_CMD_LRD) || (r_cmd == LOG_CMD_LRW));
    assign w_wr = w_byte && w_hit && cfg_type[1] &&
                  ((r_cmd == LOG_CMD_LWR) || (r_cmd == LOG_CMD_LRW));

    assign w_rd_hit_nxt = r_rd_hit | w_rd;
    assign w_wr_hit_nxt = r_wr_hit | w_wr;

    always_comb begin
        w_wkc = 2'd0;
        if (r_cmd == LOG_CMD_LRD)
            w_wkc = {1'b0, w_rd_hit_nxt};
        else if (r_cmd == LOG_CMD_LWR)
            w_wkc = {1'b0, w_wr_hit_nxt};
        else
            w_wkc = {w_wr_hit_nxt, w_rd_hit_nxt};
    end

    assign bus.bus_rd    = w_rd;
    assign bus.bus_wr    = w_wr;
    assign bus.bus_addr  = (w_rd || w_wr) ? (cfg_phys_start + w_off33[15:0]) : 16'd0;
    assign bus.bus_wdata = w_wr ? rx_data : 8'd0;

    // Read data arrives one cycle after the strobe, so the tx mux is late.
    assign tx_data = r_rd_q ? bus.bus_rdata : r_rx_q;
    assign busy    = (r_state != IDLE);

    always_ff @(posedge rxc or negedge RSTN) begin
        if (!RSTN) begin
            r_state   <= IDLE;
            r_cmd     <= 8'd0;
            r_addr    <= 32'd0;
            r_len     <= 16'd0;
            r_cnt     <= 16'd0;
            r_rd_hit  <= 1'b0;
            r_wr_hit  <= 1'b0;
            r_rd_q    <= 1'b0;
            r_rx_q    <= 8'd0;
            tx_valid  <= 1'b0;
            wkc_valid <= 1'b0;
            wkc_inc   <= 2'd0;
        end else begin
            tx_valid  <= w_byte;
            r_rd_q    <= w_rd;
            wkc_valid <= 1'b0;
            wkc_inc   <= 2'd0;
            if (w_byte) begin
                r_rx_q   <= rx_data;
                r_cnt    <= r_cnt + 16'd1;
                r_rd_hit <= w_rd_hit_nxt;
                r_wr_hit <= w_wr_hit_nxt;
            end
            if (sub_start) begin
                if (w_is_log) begin
                    r_cmd    <= sub_command;
                    r_addr   <= sub_address;
                    r_len    <= sub_len;
                    r_cnt    <= 16'd0;
                    r_rd_hit <= 1'b0;
                    r_wr_hit <= 1'b0;
                    if (sub_len == 16'd0) begin
                        r_state   <= DONE;
                        wkc_valid <= 1'b1;
                    end else begin
                        r_state <= DATA;
                    end
                end else begin
                    r_state <= IDLE;
                end
            end else begin
                case (r_state)
                    DATA: begin
                        if (w_byte && w_last) begin
                            r_state   <= DONE;
                            wkc_valid <= 1'b1;
                            wkc_inc   <= w_wkc;
                        end else if (frame_end) begin
                            r_state <= IDLE;
                        end
                    end
                    DONE:    r_state <= IDLE;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/fmmu_seq_ctrl.md
# fmmu_seq_ctrl

Byte-level sequencer for one FMMU channel, sitting between the EtherCAT datagram receive stream and the process-RAM bus. It latches a logical datagram header (LRD/LWR/LRW), walks the payload one byte at a time and computes each byte's logical address. Bytes falling inside the configured FMMU window become physical RAM reads and/or writes. It also produces the pipelined transmit byte stream and the working-counter increment for the datagram.

## Interface
- LOG_CMD_LRD, 8'd10, command code for logical read
- LOG_CMD_LWR, 8'd11, command code for logical write
- LOG_CMD_LRW, 8'd12, command code for logical read-write
- rxc  in  1  byte clock; all state on rising edge
- RSTN  in  1  reset, asynchronous, active-low
- sub_start  in  1  one-cycle pulse: header fields below valid, datagram payload starts next rx_valid
- sub_command  in  8  datagram command
- sub_address  in  32  logical start address
- sub_len  in  16  payload length in bytes
- rx_valid  in  1  payload byte present on rx_data
- rx_data  in  8  payload byte
- frame_end  in  1  frame terminated (abort if datagram incomplete)
- cfg_enable  in  1  FMMU channel enabled
- cfg_log_start  in  32  FMMU logical start (reg 0x0600-0x0603)
- cfg_log_len  in  16  FMMU logical length (reg 0x0604-0x0605)
- cfg_phys_start  in  16  FMMU physical start (reg 0x0608-0x0609)
- cfg_type  in  2  bit0 read enable, bit1 write enable (reg 0x060B)
- bus_addr  out  16  process-RAM byte address
- bus_rd  out  1  read strobe
- bus_wr  out  1  write strobe
- bus_wdata  out  8  write data
- bus_rdata  in  8  read data, valid one cycle after bus_rd
- tx_valid  out  1  tx byte valid
- tx_data  out  8  outgoing payload byte
- wkc_valid  out  1  one-cycle pulse: datagram fully processed
- wkc_inc  out  2  working-counter increment, qualified by wkc_valid
- busy  out  1  state != IDLE

## Operation
- States: IDLE, DATA, DONE.
- IDLE→DATA on sub_start with a logical command. Latch command, address and length. Clear byte_cnt and rd_hit/wr_hit. Other commands stay IDLE.
- sub_start with sub_len=0 goes to DONE directly.
- DATA: each rx_valid byte has laddr = sub_address + byte_cnt, computed as 32-bit unsigned with wrap.
- A byte is in the window when cfg_enable, cfg_log_len!=0, and laddr - cfg_log_start < cfg_log_len. The subtraction is 33-bit; a negative result means no hit.
- Per byte:
  - rd = hit & cfg_type[0] & (LRD|LRW)
  - wr = hit & cfg_type[1] & (LWR|LRW)
  - bus_addr = cfg_phys_start + (laddr - cfg_log_start)[15:0], truncated to 16 bits (wraps at 0xFFFF)
- bus_rd, bus_wr, bus_addr and bus_wdata=rx_data are combinational in the byte's cycle. They are 0 whenever no strobe is active.
- LRW with both strobes on one byte: the RAM returns the old data (read-before-write). The tx byte carries the old value.
- Any rd sets rd_hit; any wr sets wr_hit.
- byte_cnt increments per rx_valid. The byte where byte_cnt = sub_len-1 moves the block to DONE.
- DONE lasts one cycle: wkc_valid=1 and wkc_inc = (rd_hit?1:0) + (wr_hit?2:0) for LRW. For LRD it is rd_hit; for LWR it is wr_hit. Then return to IDLE.
- The LRW sum saturates at 3.
- Bytes with rx_valid outside DATA are ignored: no bus access, no tx.
- frame_end in DATA before the last byte aborts to IDLE with no wkc_valid. Bus strobes already issued are not undone.
- sub_start in DATA or DONE restarts with the new header. The old datagram gives no wkc_valid.
- Config inputs are sampled live every byte; software must not change them mid-frame.

## Timing
- Reset values: bus_addr=0, bus_rd=0, bus_wr=0, bus_wdata=0, tx_valid=0, tx_data=0, wkc_valid=0, wkc_inc=0, busy=0, state IDLE.
- Bus strobes appear in the same cycle as the byte (0 latency).
- Tx has 1-cycle latency. In cycle N+1, tx_valid is registered. tx_data = bus_rdata if byte N was read-mapped, else the registered rx_data of byte N.
- Unmapped bytes pass through unchanged.
- wkc_valid rises the cycle after the last payload byte, coincident with that byte's tx_valid.
- Back-to-back rx_valid every cycle is supported. Gaps between bytes hold state.
- sub_start and rx_valid in the same cycle: the byte is ignored, and the header applies to the next byte.

## Test plan
- **Full read.** cfg log 0x00010000/len 16/phys 0x1000/type 01. LRD addr 0x00010004 len 4.
  - Required: bus_rd at 0x1004..0x1007 in consecutive cycles, tx_data = RAM contents one cycle later, wkc_inc=1.
- **Partial write.** type 10, LWR addr 0x0000FFFE len 4, window start 0x00010000.
  - Required: bytes 0-1 have no strobe; bytes 2-3 write phys_start+0/+1; wkc_inc=1; tx echoes rx_data.
- **LRW.** type 11, RAM[0x1000]=0xAA, rx byte 0x55 at logical start.
  - Required: bus_rd and bus_wr together, tx_data=0xAA, RAM ends at 0x55, wkc_inc=3.
- **Miss and disabled.** Datagram fully outside the window, then repeated with cfg_enable=0 and with cfg_log_len=0.
  - Required: no strobes, data passes through, wkc_valid with wkc_inc=0.
- **Abort.** frame_end after 2 of 6 bytes.
  - Required: return to IDLE, no wkc_valid. A following sub_start with len 1 completes normally.
- **Reset.** RSTN low mid-DATA.
  - Required: all outputs 0 immediately. The next bytes are ignored until sub_start.
